mdu: RTL

MDU -- requirements
Module: mdu

---
 rtl/mdu.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mdu.sv
`default_nettype none
// ============================================================================
// Module  : mdu
// Purpose : Multiply/divide unit with HI/LO registers and counter-modelled latency
// Rev     : 1.0  initial release
// ============================================================================
module mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        busy,
  output logic [31:0] mdRes
);

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DIV_RUN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic        wb_en_q, wb_en_d;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_zero;
  logic        div_ovf;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  assign prod_s   = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
  assign prod_u   = {32'd0, srcA} * {32'd0, srcB};
  assign div_zero = (srcB == 32'd0);
  assign div_ovf  = (srcA == 32'h8000_0000) && (srcB == 32'hFFFF_FFFF);

  // Zero and most-negative/-1 divisors are steered away from the operators,
  // whose behaviour there is undefined or traps in some simulators.
  always_comb begin
    quo_s = 32'd0;
    rem_s = 32'd0;
    quo_u = 32'd0;
    rem_u = 32'd0;
    if (!div_zero) begin
      quo_u = srcA / srcB;
      rem_u = srcA % srcB;
      if (div_ovf) begin
        quo_s = 32'h8000_0000;
        rem_s = 32'd0;
      end else begin
        quo_s = $signed(srcA) / $signed(srcB);
        rem_s = $signed(srcA) % $signed(srcB);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wb_en_d  = wb_en_q;

    case (state_q)
      IDLE: begin
        // Moves to HI/LO take priority; a start on those ops is not a launch.
        if (mdOp == MD_MTHI) begin
          hi_d = srcA;
        end else if (mdOp == MD_MTLO) begin
          lo_d = srcA;
        end else if (start) begin
          case (mdOp)
            MD_MULT: begin
              res_hi_d = prod_s[63:32];
              res_lo_d = prod_s[31:0];
              wb_en_d  = 1'b1;
              cnt_d    = MUL_CYCLES;
              state_d  = MUL_RUN;
            end
            MD_MULTU: begin
              res_hi_d = prod_u[63:32];
              res_lo_d = prod_u[31:0];
              wb_en_d  = 1'b1;
              cnt_d    = MUL_CYCLES;
              state_d  = MUL_RUN;
            end
            MD_DIV: begin
              res_hi_d = rem_s;
              res_lo_d = quo_s;
              wb_en_d  = ~div_zero;
              cnt_d    = DIV_CYCLES;
              state_d  = DIV_RUN;
            end
            MD_DIVU: begin
              res_hi_d = rem_u;
              res_lo_d = quo_u;
              wb_en_d  = ~div_zero;
              cnt_d    = DIV_CYCLES;
              state_d  = DIV_RUN;
            end
            default: ;
          endcase
        end
      end
      MUL_RUN, DIV_RUN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
          if (wb_en_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      wb_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wb_en_q  <= wb_en_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    mdRes = 32'd0;
    if (mdOp == MD_MFHI) begin
      mdRes = hi_q;
    end else if (mdOp == MD_MFLO) begin
      mdRes = lo_q;
    end
  end

endmodule
`default_nettype wire
